serial_crc_engine: RTL

SERIAL_CRC_ENGINE -- requirements
Module: serial_crc_engine

---
 rtl/serial_crc_engine.sv | 99 +++++++++
 1 files changed

// File: rtl/serial_crc_engine.sv
// Beat-parallel CRC engine: folds DATA_W bits per accepted beat into a CRC_W register
// and presents one registered result per frame through a valid/ready handshake.
module serial_crc_engine #(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter int               DATA_W  = 8,
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT  = '0,
    parameter logic [CRC_W-1:0] RESIDUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc,
    output logic              out_match,
    output logic [CRC_W-1:0]  crc_state
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CRC_W-1:0]   r_crc;
    logic [CRC_W-1:0]   r_out_crc;
    logic               r_out_match;
    logic               w_accept;
    logic               w_release;
    logic [CRC_W-1:0]   w_base;
    logic [CRC_W-1:0]   w_crc_nxt;

    // Unrolled bit-serial LFSR: the whole beat is folded in within one cycle.
    function automatic logic [CRC_W-1:0] f_advance(input logic [CRC_W-1:0] c,
                                                   input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             b;
        r = c;
        for (int i = 0; i < DATA_W; i++) begin
            b = REFIN ? d[i] : d[DATA_W-1-i];
            r = (r << 1) ^ ((b ^ r[CRC_W-1]) ? POLY : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] f_reflect(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
        return r;
    endfunction

    assign in_ready  = (r_state != S_HOLD);
    assign out_valid = (r_state == S_HOLD);
    assign out_crc   = r_out_crc;
    assign out_match = r_out_match;
    assign crc_state = r_crc;

    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;
    // A beat arriving with no open frame always restarts from INIT.
    assign w_base    = (in_sof || r_state == S_IDLE) ? INIT : r_crc;
    assign w_crc_nxt = f_advance(w_base, in_data);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_ACCUM: if (w_accept)  w_state_nxt = in_eof ? S_HOLD : S_ACCUM;
            S_HOLD:          if (out_ready) w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc       <= INIT;
            r_out_crc   <= '0;
            r_out_match <= 1'b0;
        end else begin
            if (w_accept)       r_crc <= w_crc_nxt;
            else if (w_release) r_crc <= INIT;
            if (w_accept && in_eof) begin
                r_out_crc   <= (REFOUT ? f_reflect(w_crc_nxt) : w_crc_nxt) ^ XOROUT;
                r_out_match <= (w_crc_nxt == RESIDUE);
            end
        end
    end

endmodule
